// File: rtl/vme_system_arbiter.sv
// vme_system_arbiter
// VMEbus slot-1 system controller: samples BR3..BR0, drives the BGxOUT
// daisy-chain grants, tracks ownership through BBSY and runs the global
// bus timer that raises BERR on stalled data transfers.
//
// Build option: define VME_BUS_CLEAR_EN to build the BCLR logic
// (fixed-priority mode only). Without it vme_bus_clear is tied high.
//
// state  | meaning
// IDLE   | no grant outstanding; choose a level when BR pending and BBSY high
// GRANT  | one BGxOUT held low, waiting for the requester to take BBSY
// OWNED  | requester holds BBSY; wait for its release
// SETTLE | bus released; idle gap before the next grant
module vme_system_arbiter #(
  parameter int ARB_MODE      = 0,
  parameter int GRANT_TIMEOUT = 64,
  parameter int BUS_TIMEOUT   = 1024,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       syscon_en,
  input  logic [3:0] vme_bus_request,
  input  logic       vme_bus_busy,
  input  logic       vme_as,
  input  logic [1:0] vme_ds,
  input  logic       vme_dtack,
  input  logic       vme_berr_in,
  output logic [3:0] vme_bus_grant_out,
  output logic       vme_berr_out,
  output logic       vme_bus_clear,
  output logic [1:0] arb_owner,
  output logic       arb_active
);

  typedef enum logic [1:0] {IDLE, GRANT, OWNED, SETTLE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] GRANT_LAST  = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUS_LIMIT   = CNT_W'(BUS_TIMEOUT);
  localparam logic [CNT_W-1:0] BUS_LAST    = CNT_W'(BUS_TIMEOUT - 1);

  logic [9:0]       sync_m, sync_s;
  logic [3:0]       br_s;
  logic             bbsy_s, as_s, dtack_s, berri_s;
  logic [1:0]       ds_s;

  state_t           state;
  logic [3:0]       bg_q;
  logic [1:0]       owner_q;
  logic             active_q;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] arb_cnt;

  logic [CNT_W-1:0] bus_cnt;
  logic             berr_q;
  logic             bus_run;

  logic             pick_valid;
  logic [1:0]       pick_lvl;
  logic [1:0]       cand;

  // two-flop synchroniser for every VME input; idle (high) out of reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_m <= '1;
      sync_s <= '1;
    end else begin
      sync_m <= {vme_bus_request, vme_bus_busy, vme_as, vme_ds, vme_dtack, vme_berr_in};
      sync_s <= sync_m;
    end
  end

  assign br_s    = sync_s[9:6];
  assign bbsy_s  = sync_s[5];
  assign as_s    = sync_s[4];
  assign ds_s    = sync_s[3:2];
  assign dtack_s = sync_s[1];
  assign berri_s = sync_s[0];

  // level selection: highest pending, or first pending below the pointer
  always_comb begin
    pick_valid = 1'b0;
    pick_lvl   = 2'd0;
    cand       = 2'd0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < 4; i++) begin
        if (!br_s[i]) begin
          pick_valid = 1'b1;
          pick_lvl   = 2'(i);
        end
      end
    end else begin
      // later iterations win, so ptr-1 is examined last and has priority
      for (int i = 4; i >= 1; i--) begin
        cand = rr_ptr - 2'(i);
        if (!br_s[cand]) begin
          pick_valid = 1'b1;
          pick_lvl   = cand;
        end
      end
    end
  end

  // arbitration FSM with registered grant/status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bg_q     <= 4'b1111;
      owner_q  <= 2'd0;
      active_q <= 1'b0;
      rr_ptr   <= 2'd3;
      arb_cnt  <= '0;
    end else if (!syscon_en) begin
      state    <= IDLE;
      bg_q     <= 4'b1111;
      owner_q  <= 2'd0;
      active_q <= 1'b0;
      arb_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && bbsy_s) begin
            bg_q     <= ~(4'b0001 << pick_lvl);
            owner_q  <= pick_lvl;
            active_q <= 1'b1;
            arb_cnt  <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!bbsy_s) begin
            bg_q  <= 4'b1111;
            state <= OWNED;
            if (ARB_MODE != 0) rr_ptr <= owner_q;
          end else if (arb_cnt == GRANT_LAST) begin
            bg_q     <= 4'b1111;
            active_q <= 1'b0;
            state    <= IDLE;
          end else begin
            arb_cnt <= arb_cnt + CNT_ONE;
          end
        end
        OWNED: begin
          if (bbsy_s) begin
            active_q <= 1'b0;
            arb_cnt  <= '0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (!bbsy_s) begin
            active_q <= 1'b1;
            state    <= OWNED;
          end else if (arb_cnt == SETTLE_LAST) begin
            state <= IDLE;
          end else begin
            arb_cnt <= arb_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_run = !as_s && (ds_s != 2'b11) && dtack_s && berri_s;

  // global bus timer: saturating count of unanswered strobe cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_cnt <= '0;
      berr_q  <= 1'b1;
    end else if (!syscon_en || ds_s == 2'b11) begin
      bus_cnt <= '0;
      berr_q  <= 1'b1;
    end else if (bus_run) begin
      if (bus_cnt != BUS_LIMIT) bus_cnt <= bus_cnt + CNT_ONE;
      if (bus_cnt >= BUS_LAST) berr_q <= 1'b0;
    end
  end

`ifdef VME_BUS_CLEAR_EN
  logic higher_req;
  logic bclr_q;

  always_comb begin
    higher_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(owner_q) && !br_s[i]) higher_req = 1'b1;
    end
  end

  // BCLR: ask the owner to release when a higher level is waiting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bclr_q <= 1'b1;
    end else if (!syscon_en || state != OWNED || bbsy_s) begin
      bclr_q <= 1'b1;
    end else if (ARB_MODE == 0 && higher_req) begin
      bclr_q <= 1'b0;
    end
  end

  assign vme_bus_clear = bclr_q;
`else
  assign vme_bus_clear = 1'b1;
`endif

  assign vme_bus_grant_out = bg_q;
  assign vme_berr_out      = berr_q;
  assign arb_owner         = owner_q;
  assign arb_active        = active_q;

endmodule

// File: tb/tb_vme_system_arbiter.sv
// Bench for vme_system_arbiter: a PRI instance and an RRS instance run
// against a cycle-level behavioural model, plus directed scenarios.
module tb_vme_system_arbiter;

  localparam int P_IDLE   = 0;
  localparam int P_GRANT  = 1;
  localparam int P_OWNED  = 2;
  localparam int P_SETTLE = 3;

  typedef struct packed {
    int         phase;
    int         t0;
    int         busq;
    logic [1:0] ptr;
    logic [3:0] bg;
    logic [1:0] owner;
    logic       active;
    logic       berr;
    logic       bclr;
  } mst_t;

  logic       clock;
  logic       reset;
  logic       en    [2];
  logic [3:0] br    [2];
  logic       bbsy  [2];
  logic       as_n  [2];
  logic [1:0] ds    [2];
  logic       dtack [2];
  logic       berri [2];
  logic [3:0] bg    [2];
  logic       berro [2];
  logic       bclr  [2];
  logic [1:0] own   [2];
  logic       act   [2];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  mst_t ms    [2];
  logic [9:0] hist [2][3];

  vme_system_arbiter #(.ARB_MODE(0), .GRANT_TIMEOUT(64), .BUS_TIMEOUT(1024),
                       .SETTLE_CYCLES(2), .CNT_W(11)) u_pri (
    .clock(clock), .reset(reset), .syscon_en(en[0]),
    .vme_bus_request(br[0]), .vme_bus_busy(bbsy[0]), .vme_as(as_n[0]),
    .vme_ds(ds[0]), .vme_dtack(dtack[0]), .vme_berr_in(berri[0]),
    .vme_bus_grant_out(bg[0]), .vme_berr_out(berro[0]), .vme_bus_clear(bclr[0]),
    .arb_owner(own[0]), .arb_active(act[0]));

  vme_system_arbiter #(.ARB_MODE(1), .GRANT_TIMEOUT(16), .BUS_TIMEOUT(64),
                       .SETTLE_CYCLES(2), .CNT_W(11)) u_rrs (
    .clock(clock), .reset(reset), .syscon_en(en[1]),
    .vme_bus_request(br[1]), .vme_bus_busy(bbsy[1]), .vme_as(as_n[1]),
    .vme_ds(ds[1]), .vme_dtack(dtack[1]), .vme_berr_in(berri[1]),
    .vme_bus_grant_out(bg[1]), .vme_berr_out(berro[1]), .vme_bus_clear(bclr[1]),
    .arb_owner(own[1]), .arb_active(act[1]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic mst_t mreset();
    mst_t m;
    m.phase = P_IDLE; m.t0 = 0; m.busq = 0; m.ptr = 2'd3; m.bg = 4'hF;
    m.owner = 2'd0; m.active = 1'b0; m.berr = 1'b1; m.bclr = 1'b1;
    return m;
  endfunction

  // One clock of the arbiter rules, applied to inputs as seen two edges ago.
  function automatic mst_t step(mst_t s, int d, logic en_v, logic [9:0] smp, int cyc_v);
    mst_t n;
    logic [3:0] r;
    logic bb, a, dk, bi;
    logic [1:0] dv;
    int pick, l, mode, gto, bto;
    mode = d;
    gto  = (d == 0) ? 64 : 16;
    bto  = (d == 0) ? 1024 : 64;
    n  = s;
    r  = smp[9:6]; bb = smp[5]; a = smp[4]; dv = smp[3:2]; dk = smp[1]; bi = smp[0];
    if (!en_v) begin
      n.phase = P_IDLE; n.bg = 4'hF; n.owner = 2'd0; n.active = 1'b0;
      n.busq = 0; n.berr = 1'b1; n.bclr = 1'b1;
      return n;
    end
    if (dv == 2'b11) begin
      n.busq = 0; n.berr = 1'b1;
    end else if (!a && dk && bi) begin
      if (s.busq < bto) n.busq = s.busq + 1;
      if (n.busq == bto) n.berr = 1'b0;
    end
    pick = -1;
    if (mode == 0) begin
      for (int i = 3; i >= 0; i--) if (pick < 0 && !r[i]) pick = i;
    end else begin
      for (int j = 1; j <= 4; j++) begin
        l = (int'(s.ptr) - j + 4) % 4;
        if (pick < 0 && !r[l]) pick = l;
      end
    end
    case (s.phase)
      P_IDLE:
        if (pick >= 0 && bb) begin
          n.phase = P_GRANT; n.bg = ~(4'b0001 << pick); n.owner = 2'(pick);
          n.active = 1'b1; n.t0 = cyc_v;
        end
      P_GRANT:
        if (!bb) begin
          n.phase = P_OWNED; n.bg = 4'hF;
          if (mode == 1) n.ptr = s.owner;
        end else if (cyc_v - s.t0 == gto) begin
          n.phase = P_IDLE; n.bg = 4'hF; n.active = 1'b0;
        end
      P_OWNED:
        if (bb) begin
          n.phase = P_SETTLE; n.t0 = cyc_v; n.active = 1'b0; n.bclr = 1'b1;
        end else begin
`ifdef VME_BUS_CLEAR_EN
          if (mode == 0)
            for (int i = 0; i < 4; i++) if (i > int'(s.owner) && !r[i]) n.bclr = 1'b0;
`endif
        end
      P_SETTLE:
        if (!bb) begin
          n.phase = P_OWNED; n.active = 1'b1;
        end else if (cyc_v - s.t0 == 2) begin
          n.phase = P_IDLE;
        end
      default: ;
    endcase
    return n;
  endfunction

  // reference model, advanced on every clock and reset asynchronously
  initial begin
    for (int d = 0; d < 2; d++) begin
      ms[d] = mreset();
      for (int k = 0; k < 3; k++) hist[d][k] = '1;
    end
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
          ms[d] = mreset();
          for (int k = 0; k < 3; k++) hist[d][k] = '1;
        end
      end else begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
          hist[d][2] = hist[d][1];
          hist[d][1] = hist[d][0];
          hist[d][0] = {br[d], bbsy[d], as_n[d], ds[d], dtack[d], berri[d]};
          ms[d] = step(ms[d], d, en[d], hist[d][2], cyc);
        end
      end
    end
  end

  // per-cycle comparison of both instances against the model
  initial begin
    logic [9:0] got, exp;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        for (int d = 0; d < 2; d++) begin
          got = {bg[d], berro[d], bclr[d], own[d], act[d]};
          exp = {ms[d].bg, ms[d].berr, ms[d].bclr, ms[d].owner, ms[d].active};
          total++;
          if (got !== exp) begin
            bad++;
            $display("FAIL model_cmp dut%0d t=%0t got bg/berr/bclr/own/act=%b required=%b",
                     d, $time, got, exp);
          end
          total++;
          if ($countones(~bg[d]) > 1) begin
            bad++;
            $display("FAIL one_grant dut%0d t=%0t got bg=%b required at most one low", d, $time, bg[d]);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t got no end required end of test", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
    end
  endtask

  task automatic wait_grant(int d, int budget, output int lvl);
    lvl = -1;
    for (int n = 0; n < budget; n++) begin
      if (bg[d] != 4'hF) break;
      tick(1);
    end
    for (int i = 0; i < 4; i++) if (!bg[d][i]) lvl = i;
    total++;
    if (lvl < 0) begin
      bad++;
      $display("FAIL grant_wait dut%0d t=%0t got bg=%b required a grant", d, $time, bg[d]);
    end
  endtask

  int lvl, n, seen;
  int rrs_exp [5] = '{2, 1, 0, 3, 2};
  int hold [2];
  int exp_bclr;

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; br[d] = 4'hF; bbsy[d] = 1'b1; as_n[d] = 1'b1;
      ds[d] = 2'b11; dtack[d] = 1'b1; berri[d] = 1'b1; hold[d] = 0;
    end
    #23 reset = 1'b1;
    tick(1);
    for (int d = 0; d < 2; d++) begin
      check("rst_bg", int'(bg[d]), 15);
      check("rst_berr", int'(berro[d]), 1);
      check("rst_bclr", int'(bclr[d]), 1);
      check("rst_owner", int'(own[d]), 0);
      check("rst_active", int'(act[d]), 0);
    end

    // fixed priority: BR3 and BR1 together, grant lands on edge 3
    br[0] = 4'b0101;
    tick(2);
    check("pri_bg_before", int'(bg[0]), 15);
    tick(1);
    check("pri_bg3", int'(bg[0]), 4'b0111);
    check("pri_owner_grant", int'(own[0]), 3);
    bbsy[0] = 1'b0; br[0] = 4'hF;
    tick(2);
    check("pri_bg_held", int'(bg[0]), 4'b0111);
    tick(1);
    check("pri_bg_release", int'(bg[0]), 15);
    check("pri_owner", int'(own[0]), 3);
    check("pri_active_owned", int'(act[0]), 1);
    bbsy[0] = 1'b1;
    tick(8);

    // round robin order with all levels pending
    br[1] = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      wait_grant(1, 40, lvl);
      check("rrs_order", lvl, rrs_exp[k]);
      bbsy[1] = 1'b0;
      tick(5);
      bbsy[1] = 1'b1;
      tick(1);
    end
    br[1] = 4'hF;
    tick(30);

    // grant timeout on level 2, then regrant to the same level
    br[0] = 4'b1011;
    wait_grant(0, 10, lvl);
    check("to_level", lvl, 2);
    n = 0;
    while (bg[0] == 4'b1011 && n < 200) begin
      tick(1);
      n++;
    end
    check("to_clocks", n, 64);
    check("to_idle_active", int'(act[0]), 0);
    tick(1);
    check("to_regrant", int'(bg[0]), 4'b1011);
    br[0] = 4'hF;
    tick(70);

    // bus timer expiry and release
    as_n[0] = 1'b0; ds[0] = 2'b10;
    n = 0;
    while (berro[0] === 1'b1 && n < 1100) begin
      tick(1);
      n++;
    end
    check("berr_clocks", n, 1026);
    ds[0] = 2'b11; as_n[0] = 1'b1;
    tick(2);
    check("berr_hold", int'(berro[0]), 0);
    tick(1);
    check("berr_release", int'(berro[0]), 1);
    // DTACK at clock 500 keeps the timer short of expiry
    as_n[0] = 1'b0; ds[0] = 2'b10; seen = 0;
    for (int c = 0; c < 1200; c++) begin
      if (c == 500) dtack[0] = 1'b0;
      tick(1);
      if (berro[0] !== 1'b1) seen = 1;
    end
    check("berr_dtack", seen, 0);
    as_n[0] = 1'b1; ds[0] = 2'b11; dtack[0] = 1'b1;
    tick(5);

    // syscon_en drop in GRANT, then async reset in OWNED
    br[0] = 4'b1110;
    wait_grant(0, 10, lvl);
    check("en_level", lvl, 0);
    en[0] = 1'b0;
    tick(1);
    check("en_bg", int'(bg[0]), 15);
    check("en_active", int'(act[0]), 0);
    check("en_owner", int'(own[0]), 0);
    en[0] = 1'b1;
    wait_grant(0, 10, lvl);
    bbsy[0] = 1'b0; br[0] = 4'hF;
    tick(4);
    check("rs_owned_active", int'(act[0]), 1);
    reset = 1'b0;
    #1;
    check("rs_bg", int'(bg[0]), 15);
    check("rs_berr", int'(berro[0]), 1);
    check("rs_bclr", int'(bclr[0]), 1);
    check("rs_owner", int'(own[0]), 0);
    check("rs_active", int'(act[0]), 0);
    reset = 1'b1; bbsy[0] = 1'b1;
    tick(1);
    check("rs_idle", int'(act[0]), 0);
    tick(5);

    // bus clear: level 1 owns, BR3 arrives
`ifdef VME_BUS_CLEAR_EN
    exp_bclr = 0;
`else
    exp_bclr = 1;
`endif
    br[0] = 4'b1101;
    wait_grant(0, 10, lvl);
    check("bclr_level", lvl, 1);
    bbsy[0] = 1'b0;
    tick(4);
    check("bclr_owned", int'(act[0]), 1);
    br[0] = 4'b0111;
    tick(4);
    check("bclr_assert", int'(bclr[0]), exp_bclr);
    bbsy[0] = 1'b1;
    tick(3);
    check("bclr_release", int'(bclr[0]), 1);
    tick(2);
    check("bclr_settle_bg", int'(bg[0]), 15);
    tick(1);
    check("bclr_bg3", int'(bg[0]), 4'b0111);
    bbsy[0] = 1'b0; br[0] = 4'hF;
    tick(5);
    bbsy[0] = 1'b1;
    tick(10);

    // randomized requesters on both instances
    for (int c = 0; c < 6000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (hold[d] > 0) begin
          hold[d]--;
          if (hold[d] == 0) bbsy[d] = 1'b1;
        end else if (bg[d] != 4'hF && $urandom_range(0, 3) == 0) begin
          bbsy[d] = 1'b0; hold[d] = $urandom_range(1, 12);
        end else if ($urandom_range(0, 199) == 0) begin
          bbsy[d] = 1'b0; hold[d] = $urandom_range(1, 4);
        end
        if ($urandom_range(0, 7) == 0) br[d] = 4'($urandom);
        if ($urandom_range(0, 15) == 0) begin
          as_n[d]  = 1'($urandom_range(0, 1));
          ds[d]    = 2'($urandom);
          dtack[d] = ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0;
        end
        berri[d] = ($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0;
        en[d]    = ($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0;
      end
      tick(1);
    end
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b1; br[d] = 4'hF; bbsy[d] = 1'b1; as_n[d] = 1'b1;
      ds[d] = 2'b11; dtack[d] = 1'b1; berri[d] = 1'b1;
    end
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vme_system_arbiter.md
Name: vme_system_arbiter

Overview:
VMEbus system-controller arbiter for slot 1. It samples the four bus-request levels BR0-BR3 and drives the per-level daisy-chain bus grants BG0OUT-BG3OUT. It tracks bus ownership through BBSY and runs the global bus timer, which asserts BERR on stalled data transfers. It sits alongside the per-board requester/data-transfer logic in the bus-logic CPLD and is enabled only when the card is installed in slot 1.

Parameters:
ARB_MODE, 0, 0 = fixed priority (PRI, BR3 highest); 1 = round-robin (RRS).
GRANT_TIMEOUT, 64, clocks to wait for BBSY after BG is asserted before withdrawing the grant.
BUS_TIMEOUT, 1024, clocks an active data strobe may remain unanswered before BERR is asserted.
SETTLE_CYCLES, 2, idle clocks after BBSY release before the next grant.
CNT_W, 11, width of the shared timer counters; must hold max(GRANT_TIMEOUT, BUS_TIMEOUT).

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
syscon_en  input  1  active-high; low forces every output inactive and the FSM to IDLE.
vme_bus_request  input  4  BR3..BR0, active-low, asynchronous to clock.
vme_bus_busy  input  1  BBSY, active-low, asynchronous.
vme_as  input  1  AS, active-low.
vme_ds  input  2  DS1/DS0, active-low.
vme_dtack  input  1  DTACK, active-low.
vme_berr_in  input  1  BERR, active-low; asserted by another agent.
vme_bus_grant_out  output  4  BG3OUT..BG0OUT, active-low.
vme_berr_out  output  1  bus-timer BERR, active-low; an open-drain enable at the pad.
vme_bus_clear  output  1  BCLR, active-low; present only with the optional feature.
arb_owner  output  2  level last granted (debug/status).
arb_active  output  1  high while the bus is granted or owned.

Behaviour:
- Reset values: vme_bus_grant_out = 4'b1111, vme_berr_out = 1, vme_bus_clear = 1, arb_owner = 0, arb_active = 0, FSM in IDLE, round-robin pointer = 3, counters = 0.
- Synchronisation:
  - All VME inputs pass through 2-flop synchronisers before use.
  - BR low at clock edge N produces BG low at edge N+3, provided the FSM is in IDLE and BBSY is high.
- FSM states: IDLE, GRANT, OWNED, SETTLE.
- IDLE:
  - Action requires at least one synchronised BR low and synchronised BBSY high.
  - Choose a level:
    - PRI mode: highest pending level.
    - RRS mode: first pending level searching downward from pointer-1, wrapping 0 to 3.
  - Drive that level's BG low; load arb_owner; go to GRANT; clear the counter.
  - Only one BG output is ever low at a time.
- GRANT:
  - Hold BG low.
  - If BBSY goes low: go to OWNED and release BG on the same edge. In RRS mode, set pointer = arb_owner.
  - If the counter reaches GRANT_TIMEOUT-1 with no BBSY: release BG and go to IDLE. The pointer is unchanged.
- OWNED: wait for synchronised BBSY high, then go to SETTLE with the counter cleared.
- SETTLE:
  - After SETTLE_CYCLES clocks, go to IDLE.
  - If BBSY goes low again during SETTLE (a requester-held bus), go back to OWNED.
- arb_active = 1 in the GRANT and OWNED states.
- Requests arriving while the FSM is not in IDLE are held by the requester and evaluated on the next IDLE. Nothing is latched by this block.
- Bus timer (independent of the FSM):
  - Counts while AS is low, any DS is low, DTACK is high and BERR_in is high.
  - Clears whenever all DS are high.
  - At BUS_TIMEOUT it drives vme_berr_out low.
  - vme_berr_out stays low until both DS are high (synchronised), then releases on the next edge.
  - The counter saturates; it does not wrap.
- syscon_en low mid-operation: on the next edge, all BG go high, BERR/BCLR are released, FSM goes to IDLE, counters clear. The pointer is retained.
- Reset mid-operation behaves as immediate asynchronous reset to the reset values.

Optional Feature:
Macro VME_BUS_CLEAR_EN.
- Defined:
  - In OWNED, if a level higher than arb_owner has BR low, assert vme_bus_clear low.
  - Hold it until BBSY goes high, then release in the same edge as the move to SETTLE.
  - Applies in PRI mode only; in RRS mode vme_bus_clear stays high.
- Undefined: the port is tied high and no BCLR logic is built.

Test Plan:
- PRI mode: BR1 and BR3 low together in IDLE -> BG3 low 3 clocks later, BG1 stays high. After BBSY low, BG3 high within 3 clocks and arb_owner = 3.
- RRS mode: BR0-BR3 held low, each grant completed with a BBSY pulse -> grant order 2, 1, 0, 3, 2.
- BG2 asserted and BBSY never asserted -> BG2 released after GRANT_TIMEOUT clocks, FSM back in IDLE, next grant also goes to level 2.
- AS and DS0 low with no DTACK -> vme_berr_out low after BUS_TIMEOUT (+2 sync) clocks; released one clock after synchronised DS high. With DTACK at clock 500, BERR is never asserted.
- syscon_en dropped while in GRANT, then reset pulsed low while in OWNED -> all outputs at inactive values immediately and FSM in IDLE.
- VME_BUS_CLEAR_EN defined, PRI mode, level 1 owns the bus, BR3 goes low -> BCLR low; BBSY released -> BCLR high, BG3 low after SETTLE_CYCLES.
